ex_wb: RTL and testbench



---
 rtl/ex_wb_pkg.sv | 77 +++++++
 rtl/ex_wb_shifter.sv | 56 +++++
 rtl/ex_wb.sv | 182 ++++++++++++++++++
 tb/tb_ex_wb.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_wb_pkg.sv
// Shared definitions for the execute/writeback stage: state encodings,
// function-field codes and the operation-class priority decode.
package ex_wb_pkg;

  localparam int DEF_W_DATA  = 32;
  localparam int DEF_W_RADDR = 4;
  localparam int DEF_W_FUNC  = 3;
  localparam int DEF_W_SHCNT = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_MEM   = 2'd2
  } state_t;

  // Operation classes, listed from lowest to highest priority
  typedef enum logic [2:0] {
    CL_NONE  = 3'd0,
    CL_MOVE  = 3'd1,
    CL_INTE  = 3'd2,
    CL_LOGIC = 3'd3,
    CL_BR    = 3'd4,
    CL_SHIFT = 3'd5,
    CL_ST    = 3'd6,
    CL_LD    = 3'd7
  } op_class_t;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_ROL = 2'b11
  } shift_mode_t;

  localparam logic [2:0] INT_ADD  = 3'b000;
  localparam logic [2:0] INT_SUB  = 3'b001;
  localparam logic [2:0] INT_SLT  = 3'b010;
  localparam logic [2:0] INT_SLTU = 3'b011;
  localparam logic [2:0] INT_NOP  = 3'b100;
  localparam logic [2:0] INT_ADD2 = 3'b101;
  localparam logic [2:0] INT_SUB2 = 3'b110;
  localparam logic [2:0] INT_NEG  = 3'b111;

  localparam logic [1:0] LG_AND = 2'b00;
  localparam logic [1:0] LG_OR  = 2'b01;
  localparam logic [1:0] LG_XOR = 2'b10;
  localparam logic [1:0] LG_NOR = 2'b11;

  localparam logic [1:0] BR_ALWAYS = 2'b00;
  localparam logic [1:0] BR_EQZ    = 2'b01;
  localparam logic [1:0] BR_NEZ    = 2'b10;
  localparam logic [1:0] BR_NEG    = 2'b11;

  // Resolve several asserted class bits to one class:
  // ld > st > shift > br > logic > inte > move
  function automatic op_class_t decode_class(
    input logic ld,
    input logic st,
    input logic sh,
    input logic br,
    input logic lg,
    input logic inte,
    input logic rsv
  );
    op_class_t cls;
    if (ld)        cls = CL_LD;
    else if (st)   cls = CL_ST;
    else if (sh)   cls = CL_SHIFT;
    else if (br)   cls = CL_BR;
    else if (lg)   cls = CL_LOGIC;
    else if (inte) cls = CL_INTE;
    else if (rsv)  cls = CL_MOVE;
    else           cls = CL_NONE;
    return cls;
  endfunction

endpackage

// File: rtl/ex_wb_shifter.sv
// Iterative shifter: moves the operand one bit position per clock.
// done is high during the last active cycle; result then holds the final value.
module ex_wb_shifter
  import ex_wb_pkg::*;
#(
  parameter int W_DATA  = DEF_W_DATA,
  parameter int W_SHCNT = DEF_W_SHCNT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  shift_mode_t        mode,
  input  logic [W_DATA-1:0]  data,
  input  logic [W_SHCNT-1:0] count,
  output logic               busy,
  output logic               done,
  output logic [W_DATA-1:0]  result
);

  logic [W_DATA-1:0]  data_q;
  logic [W_SHCNT-1:0] cnt_q;
  shift_mode_t        mode_q;
  logic [W_DATA-1:0]  step;

  // One-bit step of the current value in the latched mode
  always_comb begin
    step = data_q;
    case (mode_q)
      SH_SLL:  step = {data_q[W_DATA-2:0], 1'b0};
      SH_SRL:  step = {1'b0, data_q[W_DATA-1:1]};
      SH_SRA:  step = {data_q[W_DATA-1], data_q[W_DATA-1:1]};
      default: step = {data_q[W_DATA-2:0], data_q[W_DATA-1]};
    endcase
  end

  // Load on start, then shift and count down to zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      cnt_q  <= '0;
      mode_q <= SH_SLL;
    end else if (start) begin
      data_q <= data;
      cnt_q  <= count;
      mode_q <= mode;
    end else if (cnt_q != '0) begin
      data_q <= step;
      cnt_q  <= cnt_q - W_SHCNT'(1);
    end
  end

  assign busy   = (cnt_q != '0);
  assign done   = (cnt_q == W_SHCNT'(1));
  assign result = step;

endmodule

// File: rtl/ex_wb.sv
// Execute/writeback stage: runs single-cycle ALU/logic/move/branch ops,
// iterative shifts and req/ack memory ops, and returns writebacks to decode.
module ex_wb
  import ex_wb_pkg::*;
#(
  parameter int W_DATA  = DEF_W_DATA,
  parameter int W_RADDR = DEF_W_RADDR,
  parameter int W_FUNC  = DEF_W_FUNC,
  parameter int W_SHCNT = DEF_W_SHCNT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [W_DATA-1:0]  opr0_value_i,
  input  logic [W_DATA-1:0]  opr1_value_i,
  input  logic               ctrl_inte_i,
  input  logic               ctrl_logic_i,
  input  logic               ctrl_shift_i,
  input  logic               ctrl_ld_i,
  input  logic               ctrl_st_i,
  input  logic               ctrl_br_i,
  input  logic [W_FUNC-1:0]  func_i,
  input  logic [W_RADDR-1:0] rd_i,
  input  logic               rsv_i,
  output logic               stall_o,
  output logic               wb_o,
  output logic [W_RADDR-1:0] wb_r_o,
  output logic [W_DATA-1:0]  wb_data_o,
  output logic               br_taken_o,
  output logic [W_DATA-1:0]  br_target_o,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic [W_DATA-1:0]  mem_addr_o,
  output logic [W_DATA-1:0]  mem_wdata_o,
  input  logic [W_DATA-1:0]  mem_rdata_i,
  input  logic               mem_ack_i
);

  state_t             state_q;
  logic [W_RADDR-1:0] rd_q;
  logic               rsv_q;

  op_class_t          op_class;
  logic [W_DATA-1:0]  alu_res;
  logic               alu_wb;
  logic               br_cond;
  logic [W_SHCNT-1:0] sh_n;
  logic               sh_start;
  logic               sh_busy;
  logic               sh_done;
  logic [W_DATA-1:0]  sh_result;

  assign op_class = decode_class(ctrl_ld_i, ctrl_st_i, ctrl_shift_i, ctrl_br_i,
                                 ctrl_logic_i, ctrl_inte_i, rsv_i);
  assign sh_n     = opr1_value_i[W_SHCNT-1:0];
  assign sh_start = (state_q == ST_IDLE) && (op_class == CL_SHIFT) && (sh_n != '0);
  assign stall_o  = (state_q != ST_IDLE);

  ex_wb_shifter #(
    .W_DATA  (W_DATA),
    .W_SHCNT (W_SHCNT)
  ) u_shifter (
    .clk    (clk),
    .rst    (rst),
    .start  (sh_start),
    .mode   (shift_mode_t'(func_i[1:0])),
    .data   (opr0_value_i),
    .count  (sh_n),
    .busy   (sh_busy),
    .done   (sh_done),
    .result (sh_result)
  );

  // Single-cycle result, writeback qualifier and branch condition
  always_comb begin
    alu_res = opr0_value_i;
    alu_wb  = rsv_i;
    br_cond = 1'b0;
    case (op_class)
      CL_INTE: begin
        case (func_i)
          INT_ADD, INT_ADD2: alu_res = opr0_value_i + opr1_value_i;
          INT_SUB, INT_SUB2: alu_res = opr0_value_i - opr1_value_i;
          INT_SLT:  alu_res = {{(W_DATA-1){1'b0}},
                               ($signed(opr0_value_i) < $signed(opr1_value_i))};
          INT_SLTU: alu_res = {{(W_DATA-1){1'b0}}, (opr0_value_i < opr1_value_i)};
          INT_NEG:  alu_res = '0 - opr1_value_i;
          default:  alu_wb  = 1'b0;
        endcase
      end
      CL_LOGIC: begin
        case (func_i[1:0])
          LG_AND:  alu_res = opr0_value_i & opr1_value_i;
          LG_OR:   alu_res = opr0_value_i | opr1_value_i;
          LG_XOR:  alu_res = opr0_value_i ^ opr1_value_i;
          default: alu_res = ~(opr0_value_i | opr1_value_i);
        endcase
      end
      CL_BR: begin
        case (func_i[1:0])
          BR_ALWAYS: br_cond = 1'b1;
          BR_EQZ:    br_cond = (opr0_value_i == '0);
          BR_NEZ:    br_cond = (opr0_value_i != '0);
          default:   br_cond = opr0_value_i[W_DATA-1];
        endcase
      end
      CL_MOVE:  alu_res = opr1_value_i;
      CL_SHIFT: alu_res = opr0_value_i;
      default:  alu_wb  = 1'b0;
    endcase
  end

  // Stage FSM with registered writeback, branch and memory outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      rd_q        <= '0;
      rsv_q       <= 1'b0;
      wb_o        <= 1'b0;
      wb_r_o      <= '0;
      wb_data_o   <= '0;
      br_taken_o  <= 1'b0;
      br_target_o <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      wb_o       <= 1'b0;
      br_taken_o <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          rd_q  <= rd_i;
          rsv_q <= rsv_i;
          if (op_class == CL_LD || op_class == CL_ST) begin
            state_q     <= ST_MEM;
            mem_req_o   <= 1'b1;
            mem_we_o    <= (op_class == CL_ST);
            mem_addr_o  <= opr1_value_i;
            mem_wdata_o <= opr0_value_i;
          end else if (sh_start) begin
            state_q <= ST_SHIFT;
          end else begin
            if (alu_wb) begin
              wb_o      <= 1'b1;
              wb_r_o    <= rd_i;
              wb_data_o <= alu_res;
            end
            if (op_class == CL_BR) begin
              br_taken_o  <= br_cond;
              br_target_o <= opr1_value_i;
            end
          end
        end
        ST_SHIFT: begin
          if (sh_done) begin
            state_q <= ST_IDLE;
            if (rsv_q) begin
              wb_o      <= 1'b1;
              wb_r_o    <= rd_q;
              wb_data_o <= sh_result;
            end
          end else if (!sh_busy) begin
            state_q <= ST_IDLE;
          end
        end
        ST_MEM: begin
          if (mem_ack_i) begin
            state_q   <= ST_IDLE;
            mem_req_o <= 1'b0;
            if (rsv_q) begin
              wb_o      <= 1'b1;
              wb_r_o    <= rd_q;
              wb_data_o <= mem_we_o ? mem_wdata_o : mem_rdata_i;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_wb.sv
// Bench for ex_wb: transaction-level reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ex_wb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] opr0_value, opr1_value;
  logic        ctrl_inte, ctrl_logic, ctrl_shift, ctrl_ld, ctrl_st, ctrl_br;
  logic [2:0]  func;
  logic [3:0]  rd;
  logic        rsv;
  logic        stall, wb;
  logic [3:0]  wb_r;
  logic [31:0] wb_data;
  logic        br_taken;
  logic [31:0] br_target;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // reference model: expected outputs for the current cycle
  logic        m_stall, m_wb, m_br_taken, m_req, m_we;
  logic [3:0]  m_wb_r;
  logic [31:0] m_wb_data, m_br_target, m_addr, m_wdata;
  int          m_shift_left;
  logic        m_mem_pending, m_pend_store, m_pend_rsv;
  logic [3:0]  m_pend_rd;
  logic [31:0] m_pend_data;

  ex_wb dut (
    .clk          (clk),
    .rst          (rst),
    .opr0_value_i (opr0_value),
    .opr1_value_i (opr1_value),
    .ctrl_inte_i  (ctrl_inte),
    .ctrl_logic_i (ctrl_logic),
    .ctrl_shift_i (ctrl_shift),
    .ctrl_ld_i    (ctrl_ld),
    .ctrl_st_i    (ctrl_st),
    .ctrl_br_i    (ctrl_br),
    .func_i       (func),
    .rd_i         (rd),
    .rsv_i        (rsv),
    .stall_o      (stall),
    .wb_o         (wb),
    .wb_r_o       (wb_r),
    .wb_data_o    (wb_data),
    .br_taken_o   (br_taken),
    .br_target_o  (br_target),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata),
    .mem_ack_i    (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=0x%08h required=0x%08h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_stall = 0; m_wb = 0; m_br_taken = 0; m_req = 0; m_we = 0;
    m_wb_r = 0; m_wb_data = 0; m_br_target = 0; m_addr = 0; m_wdata = 0;
    m_shift_left = 0; m_mem_pending = 0; m_pend_store = 0; m_pend_rsv = 0;
    m_pend_rd = 0; m_pend_data = 0;
  endtask

  task automatic complete(input logic [31:0] d);
    if (m_pend_rsv) begin
      m_wb      = 1;
      m_wb_r    = m_pend_rd;
      m_wb_data = d;
    end
  endtask

  // An op presented while the stage is free: decide its effect from the rules
  task automatic accept();
    int n;
    logic [31:0] a, b, r;
    a = opr0_value; b = opr1_value;
    m_pend_rsv = rsv; m_pend_rd = rd;
    if (ctrl_ld || ctrl_st) begin
      m_mem_pending = 1; m_req = 1; m_we = !ctrl_ld;
      m_addr = b; m_wdata = a;
      m_pend_store = !ctrl_ld; m_pend_data = a;
    end else if (ctrl_shift) begin
      n = int'(b[4:0]);
      case (func[1:0])
        2'b00: r = a << n;
        2'b01: r = a >> n;
        2'b10: r = $signed(a) >>> n;
        default: r = (n == 0) ? a : ((a << n) | (a >> (32 - n)));
      endcase
      if (n == 0) complete(a);
      else begin m_shift_left = n; m_pend_data = r; end
    end else if (ctrl_br) begin
      case (func[1:0])
        2'b00: m_br_taken = 1;
        2'b01: m_br_taken = (a == 0);
        2'b10: m_br_taken = (a != 0);
        default: m_br_taken = a[31];
      endcase
      m_br_target = b;
      complete(a);
    end else if (ctrl_logic) begin
      case (func[1:0])
        2'b00: complete(a & b);
        2'b01: complete(a | b);
        2'b10: complete(a ^ b);
        default: complete(~(a | b));
      endcase
    end else if (ctrl_inte) begin
      case (func)
        3'd0, 3'd5: complete(a + b);
        3'd1, 3'd6: complete(a - b);
        3'd2: complete(($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
        3'd3: complete((a < b) ? 32'd1 : 32'd0);
        3'd7: complete(32'd0 - b);
        default: ;
      endcase
    end else if (rsv) begin
      complete(b);
    end
  endtask

  // Advance the model by one clock using the inputs currently driven
  task automatic model_next();
    m_wb = 0; m_br_taken = 0;
    if (m_shift_left > 0) begin
      m_shift_left--;
      if (m_shift_left == 0) complete(m_pend_data);
    end else if (m_mem_pending) begin
      if (mem_ack) begin
        m_mem_pending = 0; m_req = 0;
        complete(m_pend_store ? m_pend_data : mem_rdata);
      end
    end else begin
      accept();
    end
    m_stall = (m_shift_left > 0) || m_mem_pending;
  endtask

  task automatic compare();
    chk("stall", 32'(stall), 32'(m_stall));
    chk("wb", 32'(wb), 32'(m_wb));
    chk("wb_r", 32'(wb_r), 32'(m_wb_r));
    chk("wb_data", wb_data, m_wb_data);
    chk("br_taken", 32'(br_taken), 32'(m_br_taken));
    chk("br_target", br_target, m_br_target);
    chk("mem_req", 32'(mem_req), 32'(m_req));
    if (m_req) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_we", 32'(mem_we), 32'(m_we));
      if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
    end
  endtask

  task automatic run_cycle();
    model_next();
    @(negedge clk);
    cyc++;
    compare();
  endtask

  task automatic bubble();
    opr0_value = 0; opr1_value = 0; func = 0; rd = 0; rsv = 0;
    ctrl_inte = 0; ctrl_logic = 0; ctrl_shift = 0; ctrl_ld = 0; ctrl_st = 0; ctrl_br = 0;
  endtask

  task automatic set_op(input int cls, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] r, input logic v);
    bubble();
    case (cls)
      0: ctrl_ld = 1;
      1: ctrl_st = 1;
      2: ctrl_shift = 1;
      3: ctrl_br = 1;
      4: ctrl_logic = 1;
      5: ctrl_inte = 1;
      default: ;
    endcase
    func = f; opr0_value = a; opr1_value = b; rd = r; rsv = v;
  endtask

  task automatic random_op();
    int sel;
    logic [31:0] a, b;
    sel = $urandom_range(0, 7);
    a = $urandom;
    b = $urandom;
    if ($urandom_range(0, 5) == 0) a = 32'h0;
    if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
    if (sel == 2 && $urandom_range(0, 1) == 1) b = b & 32'hFFFF_FFE7;
    set_op(sel, 3'($urandom_range(0, 7)), a, b, 4'($urandom_range(0, 15)),
           $urandom_range(0, 3) != 0);
    if (sel == 7) rsv = $urandom_range(0, 1);
    if ($urandom_range(0, 3) == 0) begin
      ctrl_inte  = ctrl_inte  | ($urandom_range(0, 2) == 0);
      ctrl_logic = ctrl_logic | ($urandom_range(0, 2) == 0);
      ctrl_br    = ctrl_br    | ($urandom_range(0, 2) == 0);
      ctrl_shift = ctrl_shift | ($urandom_range(0, 4) == 0);
      ctrl_st    = ctrl_st    | ($urandom_range(0, 4) == 0);
    end
    mem_ack   = ($urandom_range(0, 2) == 0);
    mem_rdata = $urandom;
  endtask

  initial begin
    bubble();
    mem_ack = 0; mem_rdata = 0;
    model_reset();
    repeat (3) @(negedge clk);
    compare();
    #2 rst = 1'b1;
    @(negedge clk);

    // ADD with signed overflow
    set_op(5, 3'b000, 32'h7FFF_FFFF, 32'd1, 4'd3, 1'b1);
    run_cycle();
    chk("add_wb", 32'(wb), 32'd1);
    chk("add_r", 32'(wb_r), 32'd3);
    chk("add_data", wb_data, 32'h8000_0000);
    chk("add_stall", 32'(stall), 32'd0);
    bubble();
    run_cycle();

    // SRA by 4, with an OR held at the input during the stall
    set_op(2, 3'b010, 32'h8000_0000, 32'd4, 4'd5, 1'b1);
    run_cycle();
    set_op(4, 3'b001, 32'h0000_00F0, 32'h0000_000F, 4'd9, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      chk("sra_stall", 32'(stall), 32'd1);
      run_cycle();
    end
    chk("sra_stall_end", 32'(stall), 32'd0);
    chk("sra_wb", 32'(wb), 32'd1);
    chk("sra_r", 32'(wb_r), 32'd5);
    chk("sra_data", wb_data, 32'hF800_0000);
    run_cycle();
    chk("held_or_r", 32'(wb_r), 32'd9);
    chk("held_or_data", wb_data, 32'h0000_00FF);
    bubble();
    run_cycle();

    // Load with ack in the third MEM cycle
    set_op(0, 3'b000, 32'h5555_AAAA, 32'h0000_0100, 4'd2, 1'b1);
    run_cycle();
    bubble();
    for (int c = 1; c <= 3; c++) begin
      chk("ld_req", 32'(mem_req), 32'd1);
      chk("ld_addr", mem_addr, 32'h0000_0100);
      chk("ld_we", 32'(mem_we), 32'd0);
      if (c == 3) begin mem_ack = 1; mem_rdata = 32'hDEAD_BEEF; end
      run_cycle();
    end
    mem_ack = 0;
    chk("ld_wb", 32'(wb), 32'd1);
    chk("ld_data", wb_data, 32'hDEAD_BEEF);
    chk("ld_r", 32'(wb_r), 32'd2);
    chk("ld_stall", 32'(stall), 32'd0);

    // Store acknowledged in its first MEM cycle
    set_op(1, 3'b000, 32'h0000_1234, 32'h0000_0040, 4'd7, 1'b1);
    run_cycle();
    chk("st_we", 32'(mem_we), 32'd1);
    chk("st_wdata", mem_wdata, 32'h0000_1234);
    bubble();
    mem_ack = 1;
    run_cycle();
    mem_ack = 0;
    chk("st_wb", 32'(wb), 32'd1);
    chk("st_r", 32'(wb_r), 32'd7);
    chk("st_data", wb_data, 32'h0000_1234);

    // Branch on zero, then integer NOP with rsv set
    set_op(3, 3'b001, 32'h0, 32'h0000_0200, 4'd1, 1'b0);
    run_cycle();
    chk("br_taken", 32'(br_taken), 32'd1);
    chk("br_target", br_target, 32'h0000_0200);
    set_op(5, 3'b100, 32'h1, 32'h2, 4'd6, 1'b1);
    run_cycle();
    chk("br_pulse_end", 32'(br_taken), 32'd0);
    bubble();
    run_cycle();
    chk("nop_no_wb", 32'(wb), 32'd0);

    // Reset while a load is outstanding, then a stray ack
    set_op(0, 3'b000, 32'h0, 32'h0000_0300, 4'd4, 1'b1);
    run_cycle();
    bubble();
    run_cycle();
    chk("pre_rst_req", 32'(mem_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rst_req_async", 32'(mem_req), 32'd0);
    model_reset();
    compare();
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    mem_ack = 1; mem_rdata = 32'hBAD0_BAD0;
    run_cycle();
    chk("late_ack_no_wb", 32'(wb), 32'd0);
    mem_ack = 0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      random_op();
      run_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
